// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads the icache and feeds IF/ID,
// with a one-entry hold buffer for hazard stalls, redirect flush and halt.
module fetch_unit #(
    parameter logic [31:0] PC_INIT = 32'h00000000,
    parameter int unsigned WORD_W  = 32
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              ihit,
    input  logic [WORD_W-1:0] iload,
    input  logic              stall_in,
    input  logic              redirect_valid,
    input  logic [WORD_W-1:0] redirect_target,
    input  logic              halt_in,
    output logic              imemREN,
    output logic [WORD_W-1:0] imemaddr,
    output logic [WORD_W-1:0] instruction_out,
    output logic [WORD_W-1:0] pc_add4_out,
    output logic              fetch_valid,
    output logic              flush_out,
    output logic [31:0]       fetch_count
);

    typedef enum logic [1:0] {RUN, HOLD, HALTED} state_t;

    state_t            state, state_d;
    logic [WORD_W-1:0] pc, pc_d, pc_next4;
    logic [WORD_W-1:0] hold_instr, hold_instr_d;
    logic [WORD_W-1:0] hold_pc4, hold_pc4_d;
    logic [31:0]       count;

    logic              ren, fv, flush;
    logic [WORD_W-1:0] instr, pc4;

    assign pc_next4 = pc + WORD_W'(4);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= RUN;
            pc         <= WORD_W'(PC_INIT);
            hold_instr <= '0;
            hold_pc4   <= '0;
            count      <= '0;
        end else begin
            state      <= state_d;
            pc         <= pc_d;
            hold_instr <= hold_instr_d;
            hold_pc4   <= hold_pc4_d;
            if (fv)
                count <= count + 32'd1;
        end
    end

    always_comb begin
        state_d      = state;
        pc_d         = pc;
        hold_instr_d = hold_instr;
        hold_pc4_d   = hold_pc4;
        ren          = 1'b0;
        fv           = 1'b0;
        flush        = 1'b0;
        instr        = iload;
        pc4          = pc_next4;

        case (state)
            RUN: begin
                ren = 1'b1;
                if (halt_in) begin
                    state_d = HALTED;
                end else if (redirect_valid) begin
                    flush        = 1'b1;
                    pc_d         = {redirect_target[WORD_W-1:2], 2'b00};
                    hold_instr_d = '0;
                    hold_pc4_d   = '0;
                end else if (ihit && !stall_in) begin
                    fv   = 1'b1;
                    pc_d = pc_next4;
                end else if (ihit && stall_in) begin
                    hold_instr_d = iload;
                    hold_pc4_d   = pc_next4;
                    state_d      = HOLD;
                end
            end
            HOLD: begin
                instr = hold_instr;
                pc4   = hold_pc4;
                if (halt_in) begin
                    state_d = HALTED;
                end else if (redirect_valid) begin
                    flush        = 1'b1;
                    pc_d         = {redirect_target[WORD_W-1:2], 2'b00};
                    hold_instr_d = '0;
                    hold_pc4_d   = '0;
                    state_d      = RUN;
                end else if (!stall_in) begin
                    fv      = 1'b1;
                    pc_d    = hold_pc4;
                    state_d = RUN;
                end
            end
            default: ;
        endcase
    end

    // Every output is forced low while reset is held, including the data paths.
    always_comb begin
        imemREN         = n_rst & ren;
        imemaddr        = n_rst ? pc : '0;
        instruction_out = n_rst ? instr : '0;
        pc_add4_out     = n_rst ? pc4 : '0;
        fetch_valid     = n_rst & fv;
        flush_out       = n_rst & flush;
        fetch_count     = n_rst ? count : '0;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit.
module tb_fetch_unit;

    logic        clk;
    logic        n_rst;
    logic        ihit;
    logic [31:0] iload;
    logic        stall_in;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        halt_in;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic [31:0] instruction_out;
    logic [31:0] pc_add4_out;
    logic        fetch_valid;
    logic        flush_out;
    logic [31:0] fetch_count;

    int tests;
    int fails;

    fetch_unit #(.PC_INIT(32'h00000000), .WORD_W(32)) dut (
        .clk             (clk),
        .n_rst           (n_rst),
        .ihit            (ihit),
        .iload           (iload),
        .stall_in        (stall_in),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .halt_in         (halt_in),
        .imemREN         (imemREN),
        .imemaddr        (imemaddr),
        .instruction_out (instruction_out),
        .pc_add4_out     (pc_add4_out),
        .fetch_valid     (fetch_valid),
        .flush_out       (flush_out),
        .fetch_count     (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        n_rst = 1'b0;
        ihit = 1'b0;
        iload = 32'h0;
        stall_in = 1'b0;
        redirect_valid = 1'b0;
        redirect_target = 32'h0;
        halt_in = 1'b0;

        // reset state
        #3;
        chk1("rst_ren", imemREN, 1'b0);
        chk1("rst_fv", fetch_valid, 1'b0);
        chk1("rst_flush", flush_out, 1'b0);
        chk("rst_addr", imemaddr, 32'h0);
        chk("rst_cnt", fetch_count, 32'h0);
        #9;
        n_rst = 1'b1;
        #1;
        chk1("post_rst_ren", imemREN, 1'b1);
        chk("post_rst_addr", imemaddr, 32'h0);

        // sequential fetch
        ihit = 1'b1;
        iload = 32'h20010001;
        #1;
        chk1("seq0_fv", fetch_valid, 1'b1);
        chk("seq0_instr", instruction_out, 32'h20010001);
        chk("seq0_pc4", pc_add4_out, 32'h4);
        tick();
        iload = 32'h20020002;
        #1;
        chk("seq1_addr", imemaddr, 32'h4);
        chk("seq1_pc4", pc_add4_out, 32'h8);
        chk1("seq1_fv", fetch_valid, 1'b1);
        tick();
        chk("seq2_addr", imemaddr, 32'h8);
        chk("seq2_cnt", fetch_count, 32'd2);
        tick();
        tick();
        chk("seq4_addr", imemaddr, 32'h10);

        // icache miss for three cycles
        ihit = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk1("miss_ren", imemREN, 1'b1);
            chk("miss_addr", imemaddr, 32'h10);
            chk1("miss_fv", fetch_valid, 1'b0);
            tick();
        end
        ihit = 1'b1;
        #1;
        chk1("miss_hit_fv", fetch_valid, 1'b1);
        tick();
        chk("miss_after_addr", imemaddr, 32'h14);
        chk("miss_after_cnt", fetch_count, 32'd5);

        // stall with hold buffer
        tick();
        tick();
        tick();
        chk("stall_addr", imemaddr, 32'h20);
        stall_in = 1'b1;
        iload = 32'hAC010000;
        #1;
        chk1("stall_fv", fetch_valid, 1'b0);
        tick();
        ihit = 1'b0;
        iload = 32'hDEADBEEF;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk1("hold_ren", imemREN, 1'b0);
            chk("hold_instr", instruction_out, 32'hAC010000);
            chk1("hold_fv", fetch_valid, 1'b0);
            tick();
        end
        stall_in = 1'b0;
        #1;
        chk1("release_fv", fetch_valid, 1'b1);
        chk("release_pc4", pc_add4_out, 32'h24);
        chk("release_instr", instruction_out, 32'hAC010000);
        tick();
        chk("release_addr", imemaddr, 32'h24);
        chk1("release_ren", imemREN, 1'b1);
        chk("release_cnt", fetch_count, 32'd9);

        // redirect in RUN with a simultaneous hit
        ihit = 1'b1;
        redirect_valid = 1'b1;
        redirect_target = 32'h103;
        #1;
        chk1("redir_run_flush", flush_out, 1'b1);
        chk1("redir_run_fv", fetch_valid, 1'b0);
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("redir_run_addr", imemaddr, 32'h100);
        chk("redir_run_cnt", fetch_count, 32'd9);

        // redirect while holding
        stall_in = 1'b1;
        iload = 32'h11111111;
        tick();
        ihit = 1'b0;
        redirect_valid = 1'b1;
        #1;
        chk1("redir_hold_ren", imemREN, 1'b0);
        chk1("redir_hold_flush", flush_out, 1'b1);
        chk1("redir_hold_fv", fetch_valid, 1'b0);
        tick();
        redirect_valid = 1'b0;
        stall_in = 1'b0;
        iload = 32'h55555555;
        #1;
        chk1("redir_hold_after_ren", imemREN, 1'b1);
        chk("redir_hold_after_addr", imemaddr, 32'h100);
        chk("redir_hold_after_instr", instruction_out, 32'h55555555);
        chk("redir_hold_after_cnt", fetch_count, 32'd9);

        // PC wrap at the top of the address space
        redirect_valid = 1'b1;
        redirect_target = 32'hFFFFFFFF;
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("wrap_addr", imemaddr, 32'hFFFFFFFC);
        ihit = 1'b1;
        #1;
        chk("wrap_pc4", pc_add4_out, 32'h0);
        chk1("wrap_fv", fetch_valid, 1'b1);
        tick();
        chk("wrap_next_addr", imemaddr, 32'h0);
        chk("wrap_cnt", fetch_count, 32'd10);
        tick();
        chk("pre_halt_addr", imemaddr, 32'h4);

        // halt beats a simultaneous redirect
        halt_in = 1'b1;
        redirect_valid = 1'b1;
        redirect_target = 32'h200;
        #1;
        chk1("halt_flush", flush_out, 1'b0);
        chk1("halt_fv", fetch_valid, 1'b0);
        tick();
        halt_in = 1'b0;
        redirect_target = 32'h300;
        #1;
        chk1("halted_ren", imemREN, 1'b0);
        chk1("halted_fv", fetch_valid, 1'b0);
        chk1("halted_flush", flush_out, 1'b0);
        chk("halted_addr", imemaddr, 32'h4);
        tick();
        tick();
        redirect_valid = 1'b0;
        chk("halted_addr_late", imemaddr, 32'h4);
        chk("halted_cnt", fetch_count, 32'd11);
        chk1("halted_ren_late", imemREN, 1'b0);

        // asynchronous reset pulse in the middle of a cycle
        #2;
        n_rst = 1'b0;
        #1;
        chk1("arst_ren", imemREN, 1'b0);
        chk("arst_cnt", fetch_count, 32'h0);
        n_rst = 1'b1;
        #1;
        chk("arst_addr", imemaddr, 32'h0);
        chk1("arst_ren_resume", imemREN, 1'b1);
        chk1("arst_fv", fetch_valid, 1'b1);
        tick();
        chk("arst_next_addr", imemaddr, 32'h4);
        chk("arst_next_cnt", fetch_count, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
